// File: rtl/uart_tx.sv
// Byte-oriented 8N1 UART transmitter fed from a small FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLOCK_HZ = 625,
  parameter int unsigned BAUD     = 78,
  parameter int unsigned DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int unsigned BitTicks = CLOCK_HZ / BAUD;
  localparam int unsigned TickW    = (BitTicks > 1) ? $clog2(BitTicks) : 1;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // FIFO storage and pointers
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;

  // Serialiser state
  state_e          state_q;
  logic [TickW-1:0] tick_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q, tx_d;
  logic            last_tick;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  assign full       = (count_q == CntW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = tx_valid_i && !full;
  assign last_tick  = (tick_q == TickW'(BitTicks - 1));
  assign tx_ready_o = !full;
  assign tx_o       = tx_q;
  assign busy_o     = (state_q != StIdle) || !empty;

  // Head is popped either from idle or on the last stop tick so frames run back to back.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      pop = (state_q == StIdle) || ((state_q == StStop) && last_tick);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Line level follows the state one cycle later, keeping tx_o glitch-free.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      unique case (state_q)
        StIdle: begin
          tick_q <= '0;
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^mem_q[rd_ptr_q];
`endif
            state_q  <= StStart;
          end
        end
        StStart: begin
          if (last_tick) begin
            tick_q  <= '0;
            bit_q   <= '0;
            state_q <= StData;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        StData: begin
          if (last_tick) begin
            tick_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (last_tick) begin
            tick_q  <= '0;
            state_q <= StStop;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (last_tick) begin
            tick_q <= '0;
            if (pop) begin
              shift_q  <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
              parity_q <= ^mem_q[rd_ptr_q];
`endif
              state_q  <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: begin
          tick_q  <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-timeline model predicts pops, ready and busy; a monitor checks the line.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;

  localparam int unsigned BT    = 8;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned SLOTS = 11;
`else
  localparam int unsigned SLOTS = 10;
`endif
  localparam int unsigned FRAME = SLOTS * BT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready_o, tx_o, busy_o;

  int total = 0;
  int bad   = 0;

  uart_tx #(.CLOCK_HZ(625), .BAUD(78), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready_o),
    .tx_o       (tx_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Model: FIFO occupancy as a queue, transmitter as "free again at edge free_edge".
  int         edge_n = 0;
  int         free_edge = 0;
  logic [7:0] pend[$];
  logic [7:0] sb_q[$];
  int         start_q[$];
  logic       exp_ready = 1'b1;
  logic       exp_busy = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend.delete();
      sb_q.delete();
      start_q.delete();
      free_edge = 0;
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
    end else begin
      int  sz;
      logic acc;
      edge_n++;
      sz  = pend.size();
      acc = tx_valid && (sz < DEPTH);
      if (sz > 0 && edge_n >= free_edge) begin
        void'(pend.pop_front());
        free_edge = edge_n + FRAME;
        start_q.push_back(edge_n + 1);
      end
      if (acc) begin
        pend.push_back(tx_data);
        sb_q.push_back(tx_data);
      end
      exp_ready = (pend.size() < DEPTH);
      exp_busy  = (pend.size() > 0) || (edge_n < free_edge);
    end
  end

  // Monitor: samples on the falling edge, compares every cycle against the model.
  logic       mon_active = 1'b0;
  logic [7:0] mon_cur = 8'h00;
  int         mon_idx = 0;

  always @(negedge clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else begin
      chk("tx_ready", tx_ready_o, exp_ready);
      chk("busy", busy_o, exp_busy);
      if (!mon_active && start_q.size() > 0 && start_q[0] == edge_n) begin
        void'(start_q.pop_front());
        if (sb_q.size() > 0) mon_cur = sb_q.pop_front();
        mon_active = 1'b1;
        mon_idx    = 0;
      end
      if (mon_active) begin
        chk($sformatf("frame_bit[%0h slot %0d]", mon_cur, mon_idx / BT), tx_o,
            frame_bit(mon_cur, mon_idx / BT));
        mon_idx++;
        if (mon_idx == FRAME) mon_active = 1'b0;
      end else begin
        chk("idle_line", tx_o, 1'b1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    step();
    tx_valid = 1'b0;
    tx_data  = $urandom;
  endtask

  task automatic drain();
    int budget = 4000;
    while ((pend.size() > 0 || edge_n < free_edge + 4) && budget > 0) begin
      step();
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++;
      $display("FAIL drain_timeout: busy_o=%0b still pending %0d", busy_o, pend.size());
    end
  endtask

  // Reset after `cyc` cycles of a frame carrying b, with two more bytes queued.
  task automatic reset_mid(input logic [7:0] b, input int cyc);
    push_byte(b);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (cyc) step();
    reset = 1'b1;
    #1;
    chk("rst_mid_tx", tx_o, 1'b1);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_ready", tx_ready_o, 1'b1);
    repeat (2) step();
    reset = 1'b0;
    repeat (FRAME * 3) step();
  endtask

  initial begin
    step();
    chk("rst_tx", tx_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", tx_ready_o, 1'b1);
    step();
    reset = 1'b0;
    repeat (20) step();

    push_byte(8'hA5);
    drain();

    // Burst from idle, then a burst that overfills while a frame is on the line.
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    drain();
    push_byte(8'h10);
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    drain();

    // Bit 3 of the frame occupies line cycles 32..39 after the start bit.
    reset_mid(8'hFF, 34);
    reset_mid(8'h00, 33);
    reset_mid(8'h5A, 2);

    push_byte(8'h3C);
    push_byte(8'hC3);
    push_byte(8'h07);
    drain();

    for (int i = 0; i < 300; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = $urandom;
      step();
    end
    tx_valid = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
